// File: rtl/prienc4_2_q_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prienc_pkg;

    localparam int PRIENC_WIDTH = 4;
    localparam int PRIENC_IDX_W = $clog2(PRIENC_WIDTH);

    // One-hot vector with bit idx set.
    function automatic logic [PRIENC_WIDTH-1:0] onehot(input logic [PRIENC_IDX_W-1:0] idx);
        logic [PRIENC_WIDTH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Index of the highest set bit; 0 for an all-zero vector.
    function automatic logic [PRIENC_IDX_W-1:0] prio_idx(input logic [PRIENC_WIDTH-1:0] vec);
        logic [PRIENC_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < PRIENC_WIDTH; i++) begin
            if (vec[i]) r = PRIENC_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/prienc4_2_q_if.sv
// Request/handshake bundle between request sources, consumer and encoder.
interface prienc4_2_q_if
    import prienc_pkg::*;
#(
    parameter int WIDTH = PRIENC_WIDTH
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] req;
    logic             ack;
    logic             ovf_clr;
    logic [IDX_W-1:0] code;
    logic             valid;
    logic [WIDTH-1:0] pend;
    logic             ovf;

    modport master (
        output en, req, ack, ovf_clr,
        input  code, valid, pend, ovf
    );

    modport slave (
        input  en, req, ack, ovf_clr,
        output code, valid, pend, ovf
    );

endinterface

// File: rtl/prienc4_2_q_comb.sv
// Combinational priority encode: highest set bit wins, idx reads 0 when empty.
module prienc_comb
    import prienc_pkg::*;
#(
    parameter int WIDTH = PRIENC_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan upward so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prienc4_2_q.sv
// Registered priority encoder: captures request pulses into a pending
// register, presents the highest pending index, retires it on ack.
module prienc4_2_q
    import prienc_pkg::*;
#(
    parameter int WIDTH = PRIENC_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    prienc4_2_q_if.slave      bus
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] set_v, clr_v;
    logic             dup;
    logic [IDX_W-1:0] idx;
    logic             any;

    prienc_comb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_comb (
        .vec_i (pend_q),
        .idx_o (idx),
        .any_o (any)
    );

    // Set/clear terms; a fresh set on a bit being cleared keeps the bit.
    always_comb begin
        set_v = bus.en ? bus.req : '0;
        clr_v = '0;
        if (any && bus.ack) clr_v[idx] = 1'b1;
        pend_d = (pend_q & ~clr_v) | set_v;
        dup    = |(set_v & pend_q & ~clr_v);
        ovf_d  = dup | (ovf_q & ~bus.ovf_clr);
    end

    // Pending and sticky-overflow flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.code  = idx;
    assign bus.valid = any;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_prienc4_2_q.sv
// Directed bench for the registered priority encoder.
module tb_prienc4_2_q;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    prienc4_2_q_if #(.WIDTH(4)) bus ();

    prienc4_2_q dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.req = 4'b0000;
        bus.ack = 1'b0;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_code", 32'(bus.code), 0);
        chk("rst_pend", 32'(bus.pend), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst_n = 1'b1;

        // Mid-run async reset with P=1010 and ovf set
        bus.req = 4'b1010; tick();
        bus.req = 4'b1000; tick();
        bus.req = 4'b0000;
        chk("pre_rst_pend", 32'(bus.pend), 32'b1010);
        chk("pre_rst_code", 32'(bus.code), 3);
        chk("pre_rst_ovf", 32'(bus.ovf), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pend", 32'(bus.pend), 0);
        chk("async_valid", 32'(bus.valid), 0);
        chk("async_code", 32'(bus.code), 0);
        chk("async_ovf", 32'(bus.ovf), 0);
        tick();
        rst_n = 1'b1;
        bus.req = 4'b0100; tick();
        bus.req = 4'b0000;
        chk("post_rst_valid", 32'(bus.valid), 1);
        chk("post_rst_code", 32'(bus.code), 2);
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        chk("post_rst_drain", 32'(bus.pend), 0);

        // Priority drain
        bus.req = 4'b1111; tick();
        bus.req = 4'b0000;
        chk("drain_code3", 32'(bus.code), 3);
        chk("drain_valid3", 32'(bus.valid), 1);
        bus.ack = 1'b1;
        tick();
        chk("drain_code2", 32'(bus.code), 2);
        tick();
        chk("drain_code1", 32'(bus.code), 1);
        tick();
        chk("drain_code0", 32'(bus.code), 0);
        chk("drain_valid0", 32'(bus.valid), 1);
        tick();
        bus.ack = 1'b0;
        chk("drain_empty_valid", 32'(bus.valid), 0);
        chk("drain_empty_pend", 32'(bus.pend), 0);

        // Preemption
        bus.req = 4'b0001; tick();
        chk("pre_code0", 32'(bus.code), 0);
        chk("pre_valid", 32'(bus.valid), 1);
        bus.req = 4'b0100; tick();
        bus.req = 4'b0000;
        chk("pre_code2", 32'(bus.code), 2);
        chk("pre_pend", 32'(bus.pend), 32'b0101);
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        chk("pre_ack_code", 32'(bus.code), 0);
        chk("pre_ack_pend", 32'(bus.pend), 32'b0001);
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0;
        chk("pre_clean", 32'(bus.pend), 0);

        // Set/clear collision and overflow
        bus.req = 4'b0010; tick();
        bus.req = 4'b0000;
        chk("col_setup_code", 32'(bus.code), 1);
        bus.ack = 1'b1; bus.req = 4'b0010; tick();
        bus.ack = 1'b0; bus.req = 4'b0000;
        chk("col_pend", 32'(bus.pend), 32'b0010);
        chk("col_ovf", 32'(bus.ovf), 0);
        bus.req = 4'b0010; tick();
        bus.req = 4'b0000;
        chk("dup_ovf", 32'(bus.ovf), 1);
        chk("dup_pend", 32'(bus.pend), 32'b0010);
        bus.ovf_clr = 1'b1; tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 32'(bus.ovf), 0);
        bus.ovf_clr = 1'b1; bus.req = 4'b0010; tick();
        bus.ovf_clr = 1'b0; bus.req = 4'b0000;
        chk("dup_beats_clr", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1; bus.ack = 1'b1; tick();
        bus.ovf_clr = 1'b0; bus.ack = 1'b0;
        chk("col_clean_pend", 32'(bus.pend), 0);
        chk("col_clean_ovf", 32'(bus.ovf), 0);

        // Enable gating
        bus.en = 1'b0; bus.req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_gate_valid", 32'(bus.valid), 0);
        end
        bus.en = 1'b1; bus.req = 4'b0001; tick();
        bus.en = 1'b0; bus.req = 4'b0000;
        chk("en_setup_pend", 32'(bus.pend), 32'b0001);
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0; bus.en = 1'b1;
        chk("en_ack_pend", 32'(bus.pend), 0);

        // Idle ack
        bus.ack = 1'b1;
        tick();
        tick();
        bus.ack = 1'b0;
        chk("idle_pend", 32'(bus.pend), 0);
        chk("idle_valid", 32'(bus.valid), 0);
        chk("idle_code", 32'(bus.code), 0);
        chk("idle_ovf", 32'(bus.ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
